mem_access_stage: RTL and testbench

- Memory stage directly downstream of the ID/EX register and the EX datapath.
- Consumes the EX result plus the control bits carried through ID/EX: reg write, rd, data-mem write, and the 2-bit alu/load/pc+4 writeback select.
- Issues load/store requests to data memory over a valid/ready bus and stalls upstream while a memory op is in flight.
- Emits a single-cycle writeback packet to the WB stage.

---
 rtl/mem_access_pkg.sv | 22 ++
 rtl/mem_access_stage.sv | 129 ++++++++++++
 tb/tb_mem_access_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_access_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam int PKT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP
  } state_t;

  typedef struct packed {
    logic                  reg_write;
    logic [4:0]            rd;
    logic [PKT_DATA_W-1:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/mem_access_stage.sv
// Memory stage: issues load/store requests over a valid/ready bus and emits a one-cycle writeback pulse.
// Optional misaligned-access trap is enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [DATA_W-1:0] pc_plus_four_in,
  input  logic              data_mem_write_in,
  input  logic              reg_write_in,
  input  logic [4:0]        rd_address_in,
  input  logic [1:0]        alu_or_load_or_pc_plus_four_in,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_write,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd_address,
  output logic [DATA_W-1:0] wb_data,
  output logic              misaligned
);

  state_t            state;
  logic              cap_reg_write;
  logic [4:0]        cap_rd;
  logic              is_mem_op;
  logic [DATA_W-1:0] nonmem_data;

  always_comb begin
    is_mem_op   = data_mem_write_in | (alu_or_load_or_pc_plus_four_in == WB_SEL_LOAD);
    nonmem_data = (alu_or_load_or_pc_plus_four_in == WB_SEL_PC4) ? pc_plus_four_in : alu_result_in;
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic addr_misaligned;
  assign addr_misaligned = |alu_result_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign in_ready = (state == IDLE);

  // wb_valid, wb_reg_write and misaligned default low each cycle so they only ever pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cap_reg_write  <= 1'b0;
      cap_rd         <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_write <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_rd_address  <= '0;
      wb_data        <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misaligned     <= 1'b0;
`endif
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misaligned   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem_op) begin
              wb_valid      <= 1'b1;
              wb_data       <= nonmem_data;
              wb_rd_address <= rd_address_in;
              wb_reg_write  <= reg_write_in && (rd_address_in != 5'd0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            end else if (addr_misaligned) begin
              wb_valid      <= 1'b1;
              wb_rd_address <= rd_address_in;
              misaligned    <= 1'b1;
`endif
            end else begin
              state          <= REQ;
              cap_reg_write  <= reg_write_in;
              cap_rd         <= rd_address_in;
              dmem_req_valid <= 1'b1;
              dmem_req_write <= data_mem_write_in;
              dmem_req_addr  <= ADDR_W'(alu_result_in);
              dmem_req_wdata <= store_data_in;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            dmem_req_write <= 1'b0;
            if (dmem_req_write) begin
              state         <= IDLE;
              wb_valid      <= 1'b1;
              wb_rd_address <= cap_rd;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_valid) begin
            state         <= IDLE;
            wb_valid      <= 1'b1;
            wb_data       <= dmem_resp_rdata;
            wb_rd_address <= cap_rd;
            wb_reg_write  <= cap_reg_write && (cap_rd != 5'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a transaction-level model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [31:0] pc_plus_four_in = '0;
  logic        data_mem_write_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic [4:0]  rd_address_in = '0;
  logic [1:0]  sel_in = '0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_req_write;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid = 1'b0;
  logic [31:0] dmem_resp_rdata = '0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_data;
  logic        misaligned;

  int passed = 0;
  int total = 0;
  logic [31:0] model_wb_data = '0;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .pc_plus_four_in(pc_plus_four_in),
    .data_mem_write_in(data_mem_write_in), .reg_write_in(reg_write_in), .rd_address_in(rd_address_in),
    .alu_or_load_or_pc_plus_four_in(sel_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_write(dmem_req_write),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd_address(wb_rd_address), .wb_data(wb_data),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic we, input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
    data_mem_write_in = we;
    sel_in            = sel;
    reg_write_in      = rw;
    rd_address_in     = rd;
    alu_result_in     = alu;
    store_data_in     = sd;
    pc_plus_four_in   = pc4;
    in_valid          = 1'b1;
  endtask

  // Plays the role of upstream and data memory for one already-set op; observes everything up to the wb pulse.
  task automatic run_op(input int ready_delay, input int resp_delay, input logic [31:0] rdata,
                        output int lat, output logic got_wb, output logic [31:0] o_data, output logic [4:0] o_rd,
                        output logic o_rw, output logic o_mis, output logic o_ready_at_wb, output int busy,
                        output int req_cycles, output logic [31:0] r_addr, output logic [31:0] r_wdata,
                        output logic r_write, output int write_cycles, output logic stable, output logic pulse_ok);
    logic hs, resp_sent;
    int post_hs;
    hs = 0; resp_sent = 0; post_hs = 0;
    lat = 0; got_wb = 0; busy = 0; req_cycles = 0; write_cycles = 0; stable = 1;
    o_data = '0; o_rd = '0; o_rw = 0; o_mis = 0; o_ready_at_wb = 0; pulse_ok = 0;
    r_addr = '0; r_wdata = '0; r_write = 0;
    tick();
    in_valid = 1'b0;
    while (!got_wb && lat < 64) begin
      if (dmem_req_write) write_cycles++;
      if (wb_valid) begin
        got_wb = 1; o_data = wb_data; o_rd = wb_rd_address; o_rw = wb_reg_write;
        o_mis = misaligned; o_ready_at_wb = in_ready;
      end else begin
        if (!in_ready) busy++;
        if (dmem_req_valid) begin
          if (req_cycles == 0) begin
            r_addr = dmem_req_addr; r_wdata = dmem_req_wdata; r_write = dmem_req_write;
          end else if (dmem_req_addr !== r_addr || dmem_req_wdata !== r_wdata || dmem_req_write !== r_write) begin
            stable = 0;
          end
          req_cycles++;
          if (req_cycles > ready_delay) dmem_req_ready = 1'b1;
        end
        if (hs && !resp_sent) begin
          if (post_hs >= resp_delay - 1) begin
            dmem_resp_valid = 1'b1; dmem_resp_rdata = rdata; resp_sent = 1;
          end
          post_hs++;
        end
        tick();
        if (dmem_req_ready) hs = 1;
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        lat++;
      end
    end
    if (got_wb) begin
      tick();
      pulse_ok = !wb_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if ({dmem_req_valid, dmem_req_write, wb_valid, wb_reg_write, misaligned} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b want 00000", {dmem_req_valid, dmem_req_write, wb_valid, wb_reg_write, misaligned}); else passed++;
    total++; if ({dmem_req_addr, dmem_req_wdata, wb_data, wb_rd_address} !== '0)
      $display("[TB] FAIL reset_data: addr %h wdata %h wb_data %h rd %0d want all 0", dmem_req_addr, dmem_req_wdata, wb_data, wb_rd_address); else passed++;
    model_wb_data = '0;
  endtask

  // Expected behaviour from the transaction rules: kind 0 alu, 1 pc+4, 2 load, 3 store.
  task automatic check_txn(input string name, input int kind, input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                           input int rdy, input int rsp, input logic [31:0] rdata);
    int lat, busy, req_cycles, write_cycles, exp_lat;
    logic got_wb, o_rw, o_mis, o_ready, r_write, stable, pulse_ok, is_mem, exp_rw;
    logic [31:0] o_data, r_addr, r_wdata, exp_data;
    logic [4:0] o_rd;
    is_mem   = (kind >= 2);
    exp_lat  = !is_mem ? 0 : (kind == 3) ? rdy + 1 : rdy + rsp + 1;
    exp_data = (kind == 0) ? alu : (kind == 1) ? pc4 : (kind == 2) ? rdata : model_wb_data;
    exp_rw   = (kind != 3) && rw && (rd != 5'd0);
    set_op(kind == 3, sel, rw, rd, alu, sd, pc4);
    run_op(rdy, rsp, rdata, lat, got_wb, o_data, o_rd, o_rw, o_mis, o_ready, busy, req_cycles,
           r_addr, r_wdata, r_write, write_cycles, stable, pulse_ok);
    total++; if (!got_wb) $display("[TB] FAIL %s_wb_seen: no wb pulse within budget", name); else passed++;
    total++; if (lat != exp_lat) $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); else passed++;
    total++; if (o_data !== exp_data) $display("[TB] FAIL %s_wb_data: got %h want %h", name, o_data, exp_data); else passed++;
    total++; if (o_rw !== exp_rw) $display("[TB] FAIL %s_wb_reg_write: got %b want %b", name, o_rw, exp_rw); else passed++;
    if (kind != 3) begin
      total++; if (o_rd !== rd) $display("[TB] FAIL %s_wb_rd: got %0d want %0d", name, o_rd, rd); else passed++;
    end
    total++; if (!pulse_ok) $display("[TB] FAIL %s_pulse: got wb_valid still 1 want 0", name); else passed++;
    total++; if (o_ready !== 1'b1) $display("[TB] FAIL %s_ready_at_wb: got %b want 1", name, o_ready); else passed++;
    total++; if (busy != (is_mem ? exp_lat : 0)) $display("[TB] FAIL %s_busy_cycles: got %0d want %0d", name, busy, is_mem ? exp_lat : 0); else passed++;
    total++; if (o_mis !== 1'b0) $display("[TB] FAIL %s_misaligned: got %b want 0", name, o_mis); else passed++;
    total++; if ((req_cycles > 0) != is_mem) $display("[TB] FAIL %s_req_issued: got %0d cycles want mem=%b", name, req_cycles, is_mem); else passed++;
    total++; if (write_cycles != ((kind == 3) ? rdy + 1 : 0)) $display("[TB] FAIL %s_write_cycles: got %0d want %0d", name, write_cycles, (kind == 3) ? rdy + 1 : 0); else passed++;
    if (is_mem) begin
      total++; if (r_addr !== alu) $display("[TB] FAIL %s_req_addr: got %h want %h", name, r_addr, alu); else passed++;
      total++; if (r_write !== (kind == 3)) $display("[TB] FAIL %s_req_write: got %b want %b", name, r_write, kind == 3); else passed++;
      total++; if (!stable) $display("[TB] FAIL %s_req_stable: got changing request want stable", name); else passed++;
      if (kind == 3) begin
        total++; if (r_wdata !== sd) $display("[TB] FAIL %s_req_wdata: got %h want %h", name, r_wdata, sd); else passed++;
      end
    end
    model_wb_data = exp_data;
  endtask

  task automatic test_directed();
    check_txn("alu_op", 0, 2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 32'h0);
    check_txn("jal_rd1", 1, 2'b10, 1'b1, 5'd1, 32'h0000_0777, 32'h0, 32'h0000_0104, 0, 1, 32'h0);
    check_txn("jal_rd0", 1, 2'b10, 1'b1, 5'd0, 32'h0000_0777, 32'h0, 32'h0000_0104, 0, 1, 32'h0);
    check_txn("sel11_alu", 0, 2'b11, 1'b1, 5'd9, 32'h0000_5555, 32'h0, 32'h0000_0888, 0, 1, 32'h0);
    check_txn("load", 2, 2'b01, 1'b1, 5'd7, 32'h0000_0100, 32'h0, 32'h0, 2, 3, 32'hDEAD_BEEF);
    check_txn("store", 3, 2'b00, 1'b0, 5'd3, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0, 1, 32'h0);
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [1:0] sel;
      logic [31:0] alu;
      kind = int'($urandom_range(0, 3));
      sel  = (kind == 0) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00) : (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
      alu  = $urandom;
      if (kind >= 2) alu[1:0] = 2'b00;
      check_txn("rand", kind, sel, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), alu, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    for (int i = 0; i < 6; i++) begin
      logic [31:0] alu, pc4;
      logic use_pc;
      alu = $urandom; pc4 = $urandom; use_pc = 1'($urandom_range(0, 1));
      set_op(1'b0, use_pc ? 2'b10 : 2'b00, 1'b1, 5'(i + 1), alu, 32'h0, pc4);
      exp_q.push_back(use_pc ? pc4 : alu);
      tick();
      total++; if (wb_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b want 1 at op %0d", wb_valid, i); else passed++;
      total++; if (wb_data !== exp_q[i]) $display("[TB] FAIL b2b_data: got %h want %h at op %0d", wb_data, exp_q[i], i); else passed++;
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b want 1 at op %0d", in_ready, i); else passed++;
      model_wb_data = exp_q[i];
    end
    in_valid = 1'b0;
    tick();
    total++; if (wb_valid !== 1'b0) $display("[TB] FAIL b2b_idle: got wb_valid %b want 0", wb_valid); else passed++;
  endtask

  task automatic test_reset_mid_load();
    set_op(1'b0, 2'b01, 1'b1, 5'd4, 32'h0000_0040, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (dmem_req_valid !== 1'b1) $display("[TB] FAIL rst_load_req: got %b want 1", dmem_req_valid); else passed++;
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_wb_data = '0;
    total++; if ({dmem_req_valid, wb_valid, wb_data, dmem_req_addr} !== '0)
      $display("[TB] FAIL rst_mid_outputs: req %b wb %b data %h addr %h want all 0", dmem_req_valid, wb_valid, wb_data, dmem_req_addr); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_mid_ready: got %b want 1", in_ready); else passed++;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h1111_2222;
    tick();
    dmem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) $display("[TB] FAIL rst_stale_resp: got wb %b data %h want 0 0", wb_valid, wb_data); else passed++;
      tick();
    end
    check_txn("after_reset", 0, 2'b00, 1'b1, 5'd12, 32'h0000_ABCD, 32'h0, 32'h0, 0, 1, 32'h0);
  endtask

  task automatic test_misaligned();
    int lat, busy, req_cycles, write_cycles;
    logic got_wb, o_rw, o_mis, o_ready, r_write, stable, pulse_ok;
    logic [31:0] o_data, r_addr, r_wdata;
    logic [4:0] o_rd;
    set_op(1'b0, 2'b01, 1'b1, 5'd6, 32'h0000_0102, 32'h0, 32'h0);
    run_op(0, 1, 32'h5A5A_5A5A, lat, got_wb, o_data, o_rd, o_rw, o_mis, o_ready, busy, req_cycles,
           r_addr, r_wdata, r_write, write_cycles, stable, pulse_ok);
    total++; if (!got_wb) $display("[TB] FAIL mis_wb_seen: no wb pulse within budget"); else passed++;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    total++; if (req_cycles != 0) $display("[TB] FAIL mis_no_req: got %0d req cycles want 0", req_cycles); else passed++;
    total++; if (lat != 0) $display("[TB] FAIL mis_latency: got %0d want 0", lat); else passed++;
    total++; if (o_mis !== 1'b1) $display("[TB] FAIL mis_flag: got %b want 1", o_mis); else passed++;
    total++; if (o_rw !== 1'b0) $display("[TB] FAIL mis_reg_write: got %b want 0", o_rw); else passed++;
    total++; if (misaligned !== 1'b0) $display("[TB] FAIL mis_pulse: got %b want 0", misaligned); else passed++;
`else
    total++; if (r_addr !== 32'h0000_0102) $display("[TB] FAIL mis_addr_passthru: got %h want 00000102", r_addr); else passed++;
    total++; if (o_mis !== 1'b0) $display("[TB] FAIL mis_tied_low: got %b want 0", o_mis); else passed++;
    total++; if (o_data !== 32'h5A5A_5A5A) $display("[TB] FAIL mis_load_data: got %h want 5a5a5a5a", o_data); else passed++;
    model_wb_data = 32'h5A5A_5A5A;
`endif
    total++; if (!pulse_ok) $display("[TB] FAIL mis_wb_pulse: got wb_valid still 1 want 0"); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_ops();
    test_reset_mid_load();
    test_misaligned();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
